// File: rtl/exc_irq_ctrl_if.sv
// Bus between the interrupt controller and the core/device side.
// Signal names follow the existing core's port naming.
interface exc_irq_ctrl_if #(parameter int NCH = 4);
    logic [NCH-1:0]         irq_in;
    logic                   mask_we;
    logic [NCH-1:0]         mask_wdata;
    logic                   ExcAck;
    logic                   ERet;
    logic                   ExtIRQ;
    logic [$clog2(NCH)-1:0] irq_id;
    logic [3:0]             EStatus;
    logic [NCH-1:0]         ExtIAck;
    logic [NCH-1:0]         pending;

    modport master (
        output irq_in, mask_we, mask_wdata, ExcAck, ERet,
        input  ExtIRQ, irq_id, EStatus, ExtIAck, pending
    );
    modport slave (
        input  irq_in, mask_we, mask_wdata, ExcAck, ERet,
        output ExtIRQ, irq_id, EStatus, ExtIAck, pending
    );
endinterface

// File: rtl/exc_irq_ctrl.sv
// External interrupt controller: per-channel sync + pending capture, masked
// fixed-priority selection and a non-nesting IDLE/REQ/SERVE handshake with the core.

module exc_irq_chan #(
    parameter int SYNC      = 2,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic irqRaw,
    input  logic clr,
    output logic pend
);
    logic [SYNC-1:0] syncQ;
    logic            prevQ;
    logic            rise;

    assign rise = syncQ[SYNC-1] & ~prevQ;

    // Edge mode: a rise in the same cycle as clr keeps the bit set.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            syncQ <= '0;
            prevQ <= 1'b0;
            pend  <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC-2:0], irqRaw};
            prevQ <= syncQ[SYNC-1];
            if (EDGE_MODE) pend <= (pend & ~clr) | rise;
            else           pend <= syncQ[SYNC-1];
        end
    end
endmodule

module exc_irq_ctrl #(
    parameter int             NCH  = 4,
    parameter logic [NCH-1:0] EDGE = {NCH{1'b1}},
    parameter int             SYNC = 2
) (
    input logic           CLOCK_50,
    input logic           reset,
    exc_irq_ctrl_if.slave bus
);
    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

    state_t         state;
    logic [NCH-1:0] mask, pend, elig, sel, clr, ackQ;
    logic [IW-1:0]  id, winner;
    logic [3:0]     eStatusQ;
    logic           extIrqQ, ackNow, selElig;

    for (genvar g = 0; g < NCH; g++) begin : gChan
        exc_irq_chan #(.SYNC(SYNC), .EDGE_MODE(EDGE[g])) uChan (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .irqRaw   (bus.irq_in[g]),
            .clr      (clr[g]),
            .pend     (pend[g])
        );
    end

    assign elig   = pend & mask;
    assign ackNow = (state == REQ) && bus.ExcAck;

    // Scan high to low so the lowest eligible index wins.
    always_comb begin
        winner = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (elig[i]) winner = IW'(i);
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++)
            sel[i] = (id == IW'(i));
    end

    assign clr     = sel & {NCH{ackNow}};
    assign selElig = |(elig & sel);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mask     <= '0;
            id       <= '0;
            extIrqQ  <= 1'b0;
            eStatusQ <= 4'h0;
            ackQ     <= '0;
        end else begin
            if (bus.mask_we) mask <= bus.mask_wdata;
            ackQ <= '0;
            case (state)
                IDLE: if (|elig) begin
                    state   <= REQ;
                    id      <= winner;
                    extIrqQ <= 1'b1;
                end
                REQ: if (bus.ExcAck) begin
                    state    <= SERVE;
                    ackQ     <= clr;
                    extIrqQ  <= 1'b0;
                    eStatusQ <= 4'd1 + 4'(id);
                end else if (!selElig) begin
                    // Source withdrew (masked or level dropped) before the core took it.
                    state   <= IDLE;
                    extIrqQ <= 1'b0;
                end
                SERVE: if (bus.ERet) begin
                    state    <= IDLE;
                    eStatusQ <= 4'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ExtIRQ  = extIrqQ;
    assign bus.irq_id  = id;
    assign bus.EStatus = eStatusQ;
    assign bus.ExtIAck = ackQ;
    assign bus.pending = pend;
endmodule
